// File: rtl/demux_s_sel_m_bits_reg_if.sv
// Handshake bundle between one producer, the demux, and 2^S slot consumers.
interface demux_s_sel_m_bits_reg_if #(
  parameter int unsigned S  = 4,
  parameter int unsigned M  = 1,
  parameter int unsigned CW = 8
);
  localparam int unsigned N = 1 << S;

  logic           EN;
  logic [S-1:0]   SEL;
  logic [M-1:0]   A;
  logic           A_VALID;
  logic           A_READY;
  logic [N*M-1:0] Y;
  logic [N-1:0]   Y_VALID;
  logic [N-1:0]   Y_READY;
  logic [CW-1:0]  ACC_CNT;

  // Producer/consumer side (drives words in, takes slots out)
  modport master (
    output EN, SEL, A, A_VALID, Y_READY,
    input  A_READY, Y, Y_VALID, ACC_CNT
  );

  // Demux side
  modport slave (
    input  EN, SEL, A, A_VALID, Y_READY,
    output A_READY, Y, Y_VALID, ACC_CNT
  );
endinterface

// File: rtl/demux_s_sel_m_bits_reg.sv
// Registered 1-to-2^S demultiplexer: steers one M-bit word per cycle into
// slot SEL, each slot a one-word holding register with its own handshake.
module demux_s_sel_m_bits_reg #(
  parameter int unsigned S  = 4,
  parameter int unsigned M  = 1,
  parameter int unsigned CW = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  demux_s_sel_m_bits_reg_if.slave bus
);
  localparam int unsigned N = 1 << S;

  logic [N*M-1:0] y_q, y_d;
  logic [N-1:0]   y_valid_q, y_valid_d;
  logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
  logic           a_ready_c;
  logic           accept_c;

  // Intake is possible when the target slot is empty or being drained now
  always_comb begin
    a_ready_c = !RST && bus.EN &&
                (!y_valid_q[bus.SEL] || bus.Y_READY[bus.SEL]);
    accept_c  = a_ready_c && bus.A_VALID;
  end

  // Next-state: drains clear valids, an accept loads only the selected slot
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q & ~bus.Y_READY;
    acc_cnt_d = acc_cnt_q;
    for (int unsigned j = 0; j < N; j++) begin
      if (accept_c && (bus.SEL == S'(j))) begin
        y_d[j*M +: M] = bus.A;
        y_valid_d[j]  = 1'b1;
      end
    end
    if (accept_c) begin
      acc_cnt_d = acc_cnt_q + CW'(1);
    end
  end

  // State registers; reset wins over any same-edge accept or drain
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q       <= '0;
      y_valid_q <= '0;
      acc_cnt_q <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign bus.A_READY = a_ready_c;
  assign bus.Y       = y_q;
  assign bus.Y_VALID = y_valid_q;
  assign bus.ACC_CNT = acc_cnt_q;
endmodule

// File: tb/tb_demux_s_sel_m_bits_reg.sv
// Directed, table-driven bench for demux_s_sel_m_bits_reg (S=2, M=4, CW=8).
module tb_demux_s_sel_m_bits_reg;
  localparam int unsigned S  = 2;
  localparam int unsigned M  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned N  = 1 << S;

  typedef struct packed {
    logic           en;
    logic [S-1:0]   sel;
    logic [M-1:0]   a;
    logic           a_valid;
    logic [N-1:0]   y_ready;
    logic           exp_ready;
    logic [N*M-1:0] exp_y;
    logic [N-1:0]   exp_y_valid;
    logic [CW-1:0]  exp_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  demux_s_sel_m_bits_reg_if #(.S(S), .M(M), .CW(CW)) bus ();

  demux_s_sel_m_bits_reg #(.S(S), .M(M), .CW(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [S-1:0] sel, input logic [M-1:0] a,
                       input logic a_valid, input logic [N-1:0] y_ready);
    bus.EN      = en;
    bus.SEL     = sel;
    bus.A       = a;
    bus.A_VALID = a_valid;
    bus.Y_READY = y_ready;
  endtask

  // Called 1 unit after a rising edge: drive, check ready, cross edge, check state
  task automatic step(input string tag, input vec_t v);
    drive(v.en, v.sel, v.a, v.a_valid, v.y_ready);
    #1;
    check({tag, ".a_ready"}, 32'(bus.A_READY), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    check({tag, ".y"},       32'(bus.Y),       32'(v.exp_y));
    check({tag, ".y_valid"}, 32'(bus.Y_VALID), 32'(v.exp_y_valid));
    check({tag, ".acc_cnt"}, 32'(bus.ACC_CNT), 32'(v.exp_cnt));
  endtask

  vec_t vecs [16];

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //            en    sel   a     av    yrdy     rdy   y         yv       cnt
    vecs[0]  = '{1'b1, 2'd2, 4'h5, 1'b1, 4'b0000, 1'b1, 16'h0500, 4'b0100, 8'd1};  // steer to 2
    vecs[1]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0000, 1'b1, 16'h050A, 4'b0101, 8'd2};  // steer to 0
    vecs[2]  = '{1'b1, 2'd1, 4'h3, 1'b1, 4'b0000, 1'b1, 16'h053A, 4'b0111, 8'd3};  // fill slot 1
    vecs[3]  = '{1'b1, 2'd1, 4'h7, 1'b1, 4'b0000, 1'b0, 16'h053A, 4'b0111, 8'd3};  // slot 1 full: stall
    vecs[4]  = '{1'b1, 2'd3, 4'h7, 1'b1, 4'b0000, 1'b1, 16'h753A, 4'b1111, 8'd4};  // redirect to 3
    vecs[5]  = '{1'b1, 2'd1, 4'h9, 1'b0, 4'b0010, 1'b1, 16'h753A, 4'b1101, 8'd4};  // drain slot 1 only
    vecs[6]  = '{1'b1, 2'd0, 4'h1, 1'b1, 4'b1111, 1'b1, 16'h7531, 4'b0001, 8'd5};  // stream 1
    vecs[7]  = '{1'b1, 2'd0, 4'h2, 1'b1, 4'b1111, 1'b1, 16'h7532, 4'b0001, 8'd6};  // stream 2
    vecs[8]  = '{1'b1, 2'd0, 4'h3, 1'b1, 4'b1111, 1'b1, 16'h7533, 4'b0001, 8'd7};  // stream 3
    vecs[9]  = '{1'b1, 2'd0, 4'h4, 1'b1, 4'b1111, 1'b1, 16'h7534, 4'b0001, 8'd8};  // stream 4
    vecs[10] = '{1'b1, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b1, 16'h7B34, 4'b0101, 8'd9};  // slots 0,2 valid
    vecs[11] = '{1'b0, 2'd2, 4'hC, 1'b1, 4'b0101, 1'b0, 16'h7B34, 4'b0000, 8'd9};  // EN=0, drains go on
    vecs[12] = '{1'b0, 2'd1, 4'hD, 1'b1, 4'b0000, 1'b0, 16'h7B34, 4'b0000, 8'd9};  // EN=0, empty slot
    vecs[13] = '{1'b1, 2'd1, 4'hE, 1'b0, 4'b1111, 1'b1, 16'h7B34, 4'b0000, 8'd9};  // no valid, A ignored
    vecs[14] = '{1'b1, 2'd1, 4'h6, 1'b1, 4'b0000, 1'b1, 16'h7B64, 4'b0010, 8'd10}; // accept to 1
    vecs[15] = '{1'b1, 2'd1, 4'h8, 1'b1, 4'b0010, 1'b1, 16'h7B84, 4'b0010, 8'd11}; // load+drain same slot

    // Reset held 2 cycles with a live producer
    drive(1'b1, 2'd3, 4'hF, 1'b1, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset.a_ready", 32'(bus.A_READY), 32'd0);
    end
    check("reset.y",       32'(bus.Y),       32'h0000);
    check("reset.y_valid", 32'(bus.Y_VALID), 32'h0);
    check("reset.acc_cnt", 32'(bus.ACC_CNT), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Counter wrap: 11 so far; 244 more reaches 255, one more wraps to 0
    drive(1'b1, 2'd0, 4'h0, 1'b1, 4'b1111);
    for (int i = 0; i < 244; i++) begin
      bus.A = 4'(i);
      @(posedge clk);
      #1;
    end
    check("wrap.cnt255", 32'(bus.ACC_CNT), 32'd255);
    check("wrap.slot0",  32'(bus.Y[3:0]),  32'(4'(243)));
    bus.A = 4'h9;
    #1;
    check("wrap.a_ready", 32'(bus.A_READY), 32'd1);
    @(posedge clk);
    #1;
    check("wrap.cnt0", 32'(bus.ACC_CNT), 32'd0);
    check("wrap.y",    32'(bus.Y),       32'h7B89);

    // Accept attempt on the same edge as reset: reset wins
    drive(1'b1, 2'd3, 4'hF, 1'b1, 4'b0000);
    rst = 1'b1;
    #1;
    check("midrst.a_ready", 32'(bus.A_READY), 32'd0);
    @(posedge clk);
    #1;
    check("midrst.y",       32'(bus.Y),       32'h0000);
    check("midrst.y_valid", 32'(bus.Y_VALID), 32'h0);
    check("midrst.acc_cnt", 32'(bus.ACC_CNT), 32'd0);
    rst = 1'b0;

    // Recovery: first accept after reset lands with count 1
    step("post_rst", '{1'b1, 2'd3, 4'hF, 1'b1, 4'b0000, 1'b1, 16'hF000, 4'b1000, 8'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
